// File: rtl/n64adv_vpll_pkg.sv
// Shared definitions for the video PLL manager: state encodings, MANAGE_VPLL bit
// positions and helpers for counter sizing and output decoding.
package n64adv_vpll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TEST     = 3'd1,
    ST_ENGAGE   = 3'd2,
    ST_RUN      = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_FALLBACK = 3'd5,
    ST_ERROR    = 3'd6
  } vpll_state_e;

  localparam int USE_VPLL_BIT  = 1;
  localparam int TEST_VPLL_BIT = 0;

  // Width of a counter that has to hold the values 0 .. n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [1:0] manage_of(input vpll_state_e s);
    logic [1:0] m;
    m = 2'b00;
    case (s)
      ST_TEST: m[TEST_VPLL_BIT] = 1'b1;
      ST_ENGAGE, ST_RUN, ST_RELEASE: begin
        m[USE_VPLL_BIT]  = 1'b1;
        m[TEST_VPLL_BIT] = 1'b1;
      end
      default: m = 2'b00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vpll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous video PLL lock into SYS_CLK.
module vpll_lock_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/n64adv_vpll_manager.sv
// Video PLL manager: qualifies PLL lock, then switches VCLK between 50 and 75 MHz safely.
// Define VPLL_AUTO_RETRY_EN to retry failed lock attempts instead of going straight to ERROR.
module n64adv_vpll_manager
  import n64adv_vpll_pkg::*;
#(
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 1048575,
  parameter int SWITCH_HOLD_CYC  = 16,
  parameter int MAX_RETRY        = 3
) (
  input  logic       SYS_CLK,
  input  logic       nSRST,
  input  logic [1:0] LINEMULT_REQ,
  input  logic       VCLK_PLL_LOCKED,
  output logic [1:0] MANAGE_VPLL,
  output logic [1:0] VCLK_select,
  output logic [2:0] VPLL_STATE,
  output logic       VPLL_ERR
);

  localparam int STABLE_W = cnt_w(LOCK_STABLE_CYC);
  localparam int TMO_W    = cnt_w(LOCK_TIMEOUT_CYC);
  localparam int HOLD_W   = cnt_w(SWITCH_HOLD_CYC);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(SWITCH_HOLD_CYC - 1);

  logic                lock_s;
  logic [1:0]          req_q;
  vpll_state_e         state_q, state_d;
  logic [STABLE_W-1:0] stable_q, stable_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                err_q, err_d;
  logic [1:0]          manage_q;
  logic                vsel1_q;

`ifdef VPLL_AUTO_RETRY_EN
  // Counts failed attempts; one extra code point lets it sit at "limit exceeded".
  localparam int RETRY_W = cnt_w(MAX_RETRY + 2);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_CAP   = RETRY_W'(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  vpll_lock_sync u_lock_sync (
    .clk_i  (SYS_CLK),
    .rst_ni (nSRST),
    .async_i(VCLK_PLL_LOCKED),
    .sync_o (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    tmo_d    = tmo_q;
    hold_d   = hold_q;
    err_d    = err_q;
`ifdef VPLL_AUTO_RETRY_EN
    retry_d  = retry_q;
`endif
    // A dropped request always takes precedence over lock-driven transitions.
    case (state_q)
      ST_IDLE: if (req_q[1]) state_d = ST_TEST;
      ST_TEST: begin
        if (!req_q[1]) state_d = ST_IDLE;
        else if (lock_s && stable_q == STABLE_LAST) state_d = ST_ENGAGE;
        else if (tmo_q == TMO_LAST) state_d = ST_FALLBACK;
        else begin
          stable_d = lock_s ? stable_q + 1'b1 : '0;
          tmo_d    = tmo_q + 1'b1;
        end
      end
      ST_ENGAGE: begin
        if (!req_q[1]) state_d = ST_RELEASE;
        else if (!lock_s) state_d = ST_FALLBACK;
        else if (hold_q == HOLD_LAST) state_d = ST_RUN;
        else hold_d = hold_q + 1'b1;
      end
      ST_RUN: begin
        if (!req_q[1]) state_d = ST_RELEASE;
        else if (!lock_s) state_d = ST_FALLBACK;
      end
      ST_RELEASE: begin
        if (hold_q == HOLD_LAST) state_d = ST_IDLE;
        else hold_d = hold_q + 1'b1;
      end
      ST_FALLBACK: begin
        if (!req_q[1]) state_d = ST_IDLE;
        else if (hold_q == HOLD_LAST) begin
`ifdef VPLL_AUTO_RETRY_EN
          state_d = (retry_q <= RETRY_LIMIT) ? ST_TEST : ST_ERROR;
`else
          state_d = ST_ERROR;
`endif
        end else hold_d = hold_q + 1'b1;
      end
      ST_ERROR: if (!req_q[1]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Entry actions are shared by every path into a state.
    if (state_d != state_q) begin
      case (state_d)
        ST_TEST: begin
          stable_d = '0;
          tmo_d    = '0;
          if (state_q == ST_IDLE) begin
            err_d = 1'b0;
`ifdef VPLL_AUTO_RETRY_EN
            retry_d = '0;
`endif
          end
        end
        ST_ENGAGE, ST_RELEASE: hold_d = '0;
        ST_FALLBACK: begin
          hold_d = '0;
          err_d  = 1'b1;
`ifdef VPLL_AUTO_RETRY_EN
          retry_d = (retry_q == RETRY_CAP) ? retry_q : retry_q + 1'b1;
`endif
        end
`ifdef VPLL_AUTO_RETRY_EN
        ST_RUN: retry_d = '0;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge SYS_CLK or negedge nSRST) begin
    if (!nSRST) begin
      req_q    <= 2'b00;
      state_q  <= ST_IDLE;
      stable_q <= '0;
      tmo_q    <= '0;
      hold_q   <= '0;
      err_q    <= 1'b0;
      manage_q <= 2'b00;
      vsel1_q  <= 1'b0;
`ifdef VPLL_AUTO_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      req_q    <= LINEMULT_REQ;
      state_q  <= state_d;
      stable_q <= stable_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      manage_q <= manage_of(state_d);
      vsel1_q  <= (state_d == ST_RUN);
`ifdef VPLL_AUTO_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  assign MANAGE_VPLL = manage_q;
  assign VCLK_select = {vsel1_q, req_q[0]};
  assign VPLL_STATE  = state_q;
  assign VPLL_ERR    = err_q;

endmodule

// File: tb/tb_n64adv_vpll_manager.sv
// Self-checking bench for n64adv_vpll_manager: scripted vectors, corner sequences and
// randomized stimulus against a behavioural model (honours VPLL_AUTO_RETRY_EN).
module tb_n64adv_vpll_manager;

  localparam int STABLE  = 8;
  localparam int TMO     = 64;
  localparam int HOLD    = 4;
  localparam int RETRIES = 3;
`ifdef VPLL_AUTO_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_TEST = 1, P_ENGAGE = 2, P_RUN = 3;
  localparam int P_RELEASE = 4, P_FALLBACK = 5, P_ERROR = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic       lock;
  logic [1:0] manage, vsel;
  logic [2:0] st;
  logic       err;

  n64adv_vpll_manager #(
    .LOCK_STABLE_CYC (STABLE),
    .LOCK_TIMEOUT_CYC(TMO),
    .SWITCH_HOLD_CYC (HOLD),
    .MAX_RETRY       (RETRIES)
  ) dut (
    .SYS_CLK        (clk),
    .nSRST          (rst_n),
    .LINEMULT_REQ   (req),
    .VCLK_PLL_LOCKED(lock),
    .MANAGE_VPLL    (manage),
    .VCLK_select    (vsel),
    .VPLL_STATE     (st),
    .VPLL_ERR       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: phase number, lock streak, time spent testing,
  // remaining hold cycles and number of failed attempts.
  int         m_st, m_streak, m_elapsed, m_left, m_fails;
  bit         m_err, m_s0, m_s1;
  bit [1:0]   m_req;

  task automatic model_reset();
    m_st = P_IDLE; m_streak = 0; m_elapsed = 0; m_left = 0; m_fails = 0;
    m_err = 1'b0; m_s0 = 1'b0; m_s1 = 1'b0; m_req = 2'b00;
  endtask

  function automatic int model_fail();
    m_fails++;
    m_err  = 1'b1;
    m_left = HOLD;
    return P_FALLBACK;
  endfunction

  task automatic model_step();
    bit lk, want;
    int nx;
    lk = m_s1; want = m_req[1]; nx = m_st;
    case (m_st)
      P_IDLE: if (want) begin
        nx = P_TEST; m_streak = 0; m_elapsed = 0; m_fails = 0; m_err = 1'b0;
      end
      P_TEST: if (!want) nx = P_IDLE;
        else begin
          m_streak = lk ? m_streak + 1 : 0;
          m_elapsed++;
          if (m_streak >= STABLE) begin nx = P_ENGAGE; m_left = HOLD; end
          else if (m_elapsed >= TMO) nx = model_fail();
        end
      P_ENGAGE: if (!want) begin nx = P_RELEASE; m_left = HOLD; end
        else if (!lk) nx = model_fail();
        else begin
          m_left--;
          if (m_left == 0) begin nx = P_RUN; m_fails = 0; end
        end
      P_RUN: if (!want) begin nx = P_RELEASE; m_left = HOLD; end
        else if (!lk) nx = model_fail();
      P_RELEASE: begin
        m_left--;
        if (m_left == 0) nx = P_IDLE;
      end
      P_FALLBACK: if (!want) nx = P_IDLE;
        else begin
          m_left--;
          if (m_left == 0) begin
            if (RETRY_EN && (m_fails - 1) < RETRIES) begin
              nx = P_TEST; m_streak = 0; m_elapsed = 0;
            end else nx = P_ERROR;
          end
        end
      P_ERROR: if (!want) nx = P_IDLE;
      default: nx = P_IDLE;
    endcase
    m_st = nx;
    m_s1 = m_s0; m_s0 = lock; m_req = req;
  endtask

  function automatic logic [7:0] model_out();
    logic [1:0] mg;
    mg = (m_st == P_TEST) ? 2'b01 :
         (m_st == P_ENGAGE || m_st == P_RUN || m_st == P_RELEASE) ? 2'b11 : 2'b00;
    return {3'(m_st), mg, (m_st == P_RUN), m_req[0], m_err};
  endfunction

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check("model", {st, manage, vsel, err}, model_out());
    check("vsel_without_use", {31'd0, vsel[1] & ~manage[1]}, 32'd0);
  endtask

  task automatic do_reset();
    req = 2'b00; lock = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("reset_outputs", {st, manage, vsel, err}, 8'h00);
    tick(); tick();
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] want, input int limit, output int n);
    n = 0;
    while (st !== want && n < limit) begin tick(); n++; end
  endtask

  typedef struct {
    logic [1:0] req;
    logic       lock;
    int         cycles;
    logic [2:0] st;
    logic [1:0] manage;
    logic [1:0] vsel;
    logic       err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b1; req = 2'b00; lock = 1'b0;
    model_reset();

    vecs[0]  = '{2'b10, 1'b1, 6,   3'd1, 2'b01, 2'b00, 1'b0};
    vecs[1]  = '{2'b10, 1'b1, 4,   3'd2, 2'b11, 2'b00, 1'b0};
    vecs[2]  = '{2'b10, 1'b1, 4,   3'd3, 2'b11, 2'b10, 1'b0};
    vecs[3]  = '{2'b11, 1'b1, 1,   3'd3, 2'b11, 2'b11, 1'b0};
    vecs[4]  = '{2'b01, 1'b1, 2,   3'd4, 2'b11, 2'b01, 1'b0};
    vecs[5]  = '{2'b01, 1'b1, 4,   3'd0, 2'b00, 2'b01, 1'b0};
    vecs[6]  = '{2'b10, 1'b0, 65,  3'd1, 2'b01, 2'b00, 1'b0};
    vecs[7]  = '{2'b10, 1'b0, 1,   3'd5, 2'b00, 2'b00, 1'b1};
    vecs[8]  = '{2'b10, 1'b0, 4,   RETRY_EN ? 3'd1 : 3'd6, RETRY_EN ? 2'b01 : 2'b00, 2'b00, 1'b1};
    vecs[9]  = '{2'b10, 1'b0, 210, 3'd6, 2'b00, 2'b00, 1'b1};
    vecs[10] = '{2'b00, 1'b0, 2,   3'd0, 2'b00, 2'b00, 1'b1};
    vecs[11] = '{2'b10, 1'b1, 2,   3'd1, 2'b01, 2'b00, 1'b0};

    #1 rst_n = 1'b0;
    #1 check("reset_state", {st, manage, vsel, err}, 8'h00);
    tick();
    #2 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      req = vecs[i].req; lock = vecs[i].lock;
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d", i), {st, manage, vsel, err},
            {vecs[i].st, vecs[i].manage, vecs[i].vsel, vecs[i].err});
    end

    // Single-cycle lock loss in RUN.
    do_reset();
    req = 2'b10; lock = 1'b1;
    wait_state(3'd3, 40, n);
    check("run_latency", n, 14);
    lock = 1'b0; tick(); lock = 1'b1; n = 1;
    while (vsel[1] !== 1'b0 && n < 10) begin tick(); n++; end
    check("lockloss_latency", n, 3);
    check("lockloss_manage", {30'd0, manage}, 32'd0);

    // Asynchronous reset in RUN, then full requalification.
    do_reset();
    req = 2'b10; lock = 1'b1;
    wait_state(3'd3, 40, n);
    check("run_before_reset", {29'd0, st}, 32'd3);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("reset_in_run", {st, manage, vsel, err}, 8'h00);
    tick();
    #2 rst_n = 1'b1;
    wait_state(3'd3, 40, n);
    check("requalify_latency", n, 14);

    // Lock toggling every 5 cycles never qualifies; timeout after 64 TEST cycles.
    do_reset();
    req = 2'b10; n = 0;
    while (st !== 3'd5 && n < 100) begin
      lock = ((n / 5) % 2) == 1;
      tick(); n++;
    end
    check("toggle_timeout_cycle", n, 66);
    check("toggle_err", {31'd0, err}, 32'd1);
    repeat (HOLD) tick();
    check("toggle_after_fallback", {29'd0, st}, RETRY_EN ? 32'd1 : 32'd6);

    // Stable completion and timeout on the same cycle: stable wins.
    do_reset();
    req = 2'b10; lock = 1'b0;
    repeat (56) tick();
    lock = 1'b1;
    repeat (9) tick();
    check("tie_still_test", {29'd0, st}, 32'd1);
    tick();
    check("tie_stable_wins", {29'd0, st}, 32'd2);

    // Request drop coinciding with a timeout: drop wins.
    do_reset();
    req = 2'b10; lock = 1'b0;
    repeat (64) tick();
    req = 2'b00;
    tick(); tick();
    check("drop_beats_timeout", {st, err}, {3'd0, 1'b0});

    // Randomized operation against the model, with occasional resets.
    do_reset();
    req = 2'b10; lock = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) req[1] = ~req[1];
      if ($urandom_range(0, 29) == 0)  req[0] = ~req[0];
      if ($urandom_range(0, 79) == 0)  lock = ~lock;
      if ($urandom_range(0, 1499) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("rand_reset", {st, manage, vsel, err}, 8'h00);
        tick();
        #2 rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
